axi_rd_burst_splitter: RTL
==========================

// Module: axi_rd_burst_splitter
//
// PURPOSE
//  Read-path stage between the system AXI master port and the async AXI bridge that feeds the DDR4 controller.
//  Splits each AR burst into sub-bursts of at most MAX_BURST beats (optionally never crossing a 4 KB boundary).
//  Re-merges the returned R beats into one burst toward the system, with a single RLAST on the final beat.
//  Write channels do not pass through this block.
//
// PARAMETERS
//  AXI_ID_W    4   ID width
//  AXI_ADDR_W  30  address width
//  AXI_DATA_W  32  data width
//  AXI_LEN_W   8   burst length field width
//  MAX_BURST   16  max beats per downstream sub-burst; power of 2, <= 2**AXI_LEN_W
//
// PORTS
//  clk                    in   1           system clock; all logic on rising edge
//  rstn                   in   1           asynchronous active-low reset
//  s_axi_arid/araddr      in   ID/ADDR     upstream read address
//  s_axi_arlen/arsize     in   LEN/3       upstream burst length-1, beat size
//  s_axi_arburst          in   2           upstream burst type
//  s_axi_arcache/prot/qos in   4/3/4       forwarded unchanged on every sub-burst
//  s_axi_arvalid          in   1           upstream AR valid
//  s_axi_arready          out  1           upstream AR ready
//  s_axi_rid/rdata/rresp  out  ID/DATA/2   merged read data
//  s_axi_rlast            out  1           merged last beat
//  s_axi_rvalid           out  1           merged R valid
//  s_axi_rready           in   1           merged R ready
//  m_axi_ar*              out  as s_axi_*  downstream sub-burst AR (same field set as s_axi_ar*)
//  m_axi_arready          in   1           downstream AR ready
//  m_axi_rdata/rresp      in   DATA/2      downstream R data
//  m_axi_rid              in   ID          downstream R id (ignored)
//  m_axi_rlast            in   1           downstream sub-burst last beat
//  m_axi_rvalid           in   1           downstream R valid
//  m_axi_rready           out  1           downstream R ready
//
// BEHAVIOUR
//  - FSM: IDLE -> ISSUE -> WAIT_DATA -> (ISSUE | IDLE). One upstream burst in flight at a time.
//  - Reset: state=IDLE; m_axi_arvalid=0; s_axi_rvalid=0; m_axi_rready=0; all address/length registers 0.
//  - IDLE:
//    - s_axi_arready=1; it is 0 in every other state.
//    - On AR handshake, latch id, addr, size, burst, cache, prot, qos; remaining = arlen+1; go ISSUE.
//  - ISSUE:
//    - m_axi_arvalid=1 with m_axi_araddr=cur_addr, m_axi_arid=latched id, m_axi_arlen=chunk-1.
//    - chunk = min(remaining, MAX_BURST[, beats_to_4k]).
//    - All m_axi_ar* held stable until m_axi_arready.
//    - On handshake: remaining -= chunk; cur_addr = align(cur_addr, size) + (chunk << size), modulo 2**AXI_ADDR_W.
//    - Go WAIT_DATA.
//    - Latency from upstream AR handshake to first m_axi_arvalid: 1 cycle.
//  - WAIT_DATA (combinational pass-through):
//    - s_axi_rvalid = m_axi_rvalid; m_axi_rready = s_axi_rready.
//    - s_axi_rdata and s_axi_rresp per beat, unmodified; s_axi_rid = latched id.
//    - s_axi_rlast = m_axi_rlast & (remaining==0).
//    - On an m_axi_rlast handshake: remaining==0 -> IDLE, else -> ISSUE.
//  - Outside WAIT_DATA: m_axi_rready=0 and s_axi_rvalid=0. Stray downstream beats are stalled, never dropped.
//  - FIXED (2'b00) and WRAP (2'b10) bursts: one sub-burst, chunk = arlen+1, address unmodified.
//    A FIXED burst with arlen+1 > MAX_BURST is also forwarded unsplit.
//  - arlen=0: exactly one sub-burst with arlen=0; RLAST on that beat.
//  - Reset mid-operation: returns to IDLE immediately, discarding in-flight state. rstn must also reset the bridge/controller side.
//
// CONFIGURATION
//  AXI_SPLIT_4K_EN defined:
//    - beats_to_4k = (4096 - cur_addr[11:0]) >> size enters the min() for INCR bursts.
//    - No sub-burst crosses a 4 KB boundary.
//  AXI_SPLIT_4K_EN undefined:
//    - Only the MAX_BURST limit applies; the 4 KB logic is not synthesised.
//
// TESTING
//  1. INCR addr 0x100 size 2 arlen=15 -> one m AR arlen=15 @0x100; s_axi_rlast only on beat 16.
//  2. INCR addr 0x0 size 2 arlen=63 -> m AR arlen=15 @0x000,0x040,0x080,0x0C0.
//     s_axi_rlast only on beat 64; s_axi_arready=0 until the final beat is accepted.
//  3. INCR addr 0xFF8 size 2 arlen=7:
//     - with AXI_SPLIT_4K_EN -> arlen=1 @0xFF8, then arlen=5 @0x1000.
//     - without it -> single arlen=7 @0xFF8.
//  4. m_axi_arready low for 5 cycles during ISSUE -> m_axi_ar* stable, arvalid held, no R traffic.
//  5. arlen=31, random s_axi_rready stalls, rresp=SLVERR on beat 3 -> 32 beats in order.
//     SLVERR appears on beat 3 only; data matches the downstream model.
//  6. rstn low mid-WAIT_DATA -> s_axi_rvalid=0, m_axi_arvalid=0 immediately.
//     s_axi_arready=1 in the first cycle after rstn rises; a new burst completes normally.

Source files
------------

// File: rtl/axi_rd_burst_splitter.sv
// axi_rd_burst_splitter
// Splits each upstream AXI read burst into downstream sub-bursts of at most
// MAX_BURST beats and merges the returned R beats back into one upstream burst
// with a single RLAST. One upstream burst is in flight at a time.
// Optional feature macro: AXI_SPLIT_4K_EN keeps every INCR sub-burst inside one
// 4 KB page; when it is undefined only the MAX_BURST limit applies.
module axi_rd_burst_splitter #(
   parameter int AXI_ID_W   = 4,
   parameter int AXI_ADDR_W = 30,
   parameter int AXI_DATA_W = 32,
   parameter int AXI_LEN_W  = 8,
   parameter int MAX_BURST  = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [AXI_ID_W-1:0]   s_axi_arid,
   input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
   input  logic [AXI_LEN_W-1:0]  s_axi_arlen,
   input  logic [2:0]            s_axi_arsize,
   input  logic [1:0]            s_axi_arburst,
   input  logic [3:0]            s_axi_arcache,
   input  logic [2:0]            s_axi_arprot,
   input  logic [3:0]            s_axi_arqos,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [AXI_ID_W-1:0]   s_axi_rid,
   output logic [AXI_DATA_W-1:0] s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rlast,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [AXI_ID_W-1:0]   m_axi_arid,
   output logic [AXI_ADDR_W-1:0] m_axi_araddr,
   output logic [AXI_LEN_W-1:0]  m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic [3:0]            m_axi_arqos,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [AXI_DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic [AXI_ID_W-1:0]   m_axi_rid,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   // Remaining-beat counter must hold arlen+1, i.e. up to 2**AXI_LEN_W.
   localparam int REM_W = AXI_LEN_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t                state_q;
   logic [AXI_ID_W-1:0]   id_q;
   logic [AXI_ADDR_W-1:0] addr_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic [3:0]            cache_q;
   logic [2:0]            prot_q;
   logic [3:0]            qos_q;
   logic [REM_W-1:0]      rem_q;
   logic                  arvalid_q;

   logic [REM_W-1:0]      chunk;
   logic [AXI_ADDR_W-1:0] addr_align;
   logic [AXI_ADDR_W-1:0] addr_next;
   logic                  in_wait;
   logic                  unused_ok;
`ifdef AXI_SPLIT_4K_EN
   logic [12:0]           beats_4k;
`endif

   // Size of the next sub-burst and the address that follows it. Only INCR
   // bursts are split; FIXED and WRAP go out whole. Inputs are registers that
   // change only on a handshake, so the AR fields stay stable while stalled.
   always_comb begin
      addr_align = addr_q & ~((AXI_ADDR_W'(1) << size_q) - AXI_ADDR_W'(1));
      chunk      = rem_q;
`ifdef AXI_SPLIT_4K_EN
      // Counted from the size-aligned address so an unaligned start never
      // yields a zero-beat chunk.
      beats_4k   = (13'd4096 - {1'b0, addr_align[11:0]}) >> size_q;
`endif
      if (burst_q == 2'b01) begin
         if (chunk > REM_W'(MAX_BURST)) chunk = REM_W'(MAX_BURST);
`ifdef AXI_SPLIT_4K_EN
         if ({{REM_W{1'b0}}, beats_4k} < {13'd0, chunk}) chunk = REM_W'(beats_4k);
`endif
      end
      addr_next = addr_align + (AXI_ADDR_W'(chunk) << size_q);
   end

   assign in_wait       = (state_q == S_WAIT);
   assign s_axi_arready = (state_q == S_IDLE);

   assign m_axi_arvalid = arvalid_q;
   assign m_axi_arid    = id_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = AXI_LEN_W'(chunk - REM_W'(1));
   assign m_axi_arsize  = size_q;
   assign m_axi_arburst = burst_q;
   assign m_axi_arcache = cache_q;
   assign m_axi_arprot  = prot_q;
   assign m_axi_arqos   = qos_q;

   // R pass-through is open only while a sub-burst is outstanding; beats
   // arriving at any other time are back-pressured, never dropped.
   assign s_axi_rvalid  = in_wait & m_axi_rvalid;
   assign m_axi_rready  = in_wait & s_axi_rready;
   assign s_axi_rdata   = m_axi_rdata;
   assign s_axi_rresp   = m_axi_rresp;
   assign s_axi_rid     = id_q;
   assign s_axi_rlast   = in_wait & m_axi_rlast & (rem_q == '0);

   // Downstream RID is not needed: only one sub-burst is ever outstanding.
   assign unused_ok     = ^m_axi_rid;

   // Control FSM: accept one upstream burst, issue its sub-bursts one at a
   // time and wait for each sub-burst's last beat before issuing the next.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         arvalid_q <= 1'b0;
         id_q      <= '0;
         addr_q    <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         cache_q   <= '0;
         prot_q    <= '0;
         qos_q     <= '0;
         rem_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (s_axi_arvalid) begin
                  id_q      <= s_axi_arid;
                  addr_q    <= s_axi_araddr;
                  size_q    <= s_axi_arsize;
                  burst_q   <= s_axi_arburst;
                  cache_q   <= s_axi_arcache;
                  prot_q    <= s_axi_arprot;
                  qos_q     <= s_axi_arqos;
                  rem_q     <= REM_W'(s_axi_arlen) + REM_W'(1);
                  arvalid_q <= 1'b1;
                  state_q   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (m_axi_arready) begin
                  arvalid_q <= 1'b0;
                  rem_q     <= rem_q - chunk;
                  addr_q    <= addr_next;
                  state_q   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (m_axi_rvalid && s_axi_rready && m_axi_rlast) begin
                  if (rem_q == '0) begin
                     state_q   <= S_IDLE;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= S_ISSUE;
                  end
               end
            end
            default: begin
               arvalid_q <= 1'b0;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
